// File: rtl/conv_corriente_bcd_if.sv
// conv_corriente_bcd_if: start/done handshake and result bus of the current-to-BCD converter
interface conv_corriente_bcd_if #(
  parameter int IN_W   = 5,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [IN_W-1:0]       corriente;
  logic [4*DIGITS-1:0]   digitos;
  logic                  busy;
  logic                  done;
  logic                  err;
  modport master (output start, corriente, input digitos, busy, done, err);
  modport slave  (input start, corriente, output digitos, busy, done, err);
endinterface

// File: rtl/conv_corriente_bcd.sv
// conv_corriente_bcd: scales a current code by STEP and converts it to blanked BCD via double-dabble
module conv_corriente_bcd #(
  parameter int          IN_W    = 5,
  parameter int          STEP    = 50,
  parameter int          MAX_VAL = 20,
  parameter int          DIGITS  = 4,
  parameter logic [3:0]  BLANK   = 4'hA
) (
  input  logic            clk,
  input  logic            reset,
  conv_corriente_bcd_if.slave bus
);
  localparam int PW = IN_W + $clog2(STEP + 1);
  localparam int DW = 4 * DIGITS;
  localparam int CW = $clog2(PW + 1);
  localparam logic [DW-1:0] RST_DIG = {{(DIGITS-1){BLANK}}, 4'h0};
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FMT} state_t;
  state_t          state, next;
  logic [IN_W-1:0] code;
  logic [PW-1:0]   prod;
  logic [DW-1:0]   scratch, adj, fin, shown, digitos;
  logic [CW-1:0]   cnt;
  logic            err, bad, seen, accept, last;
  // the done cycle also accepts a new start, so back-to-back requests cost no idle cycle
  assign accept = bus.start && (state == IDLE || state == FMT);
  assign last   = state == SHIFT && cnt == CW'(1);
  assign bad    = int'(code) > MAX_VAL;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next;
  // next-state logic
  always_comb
    next = accept          ? LOAD  :
           state == LOAD   ? SHIFT :
           state == SHIFT  ? (last ? FMT : SHIFT) :
                             IDLE;
  // add-3 correction on every BCD digit that is 5 or more, then the shifted scratch value
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++)
      adj[4*d +: 4] = scratch[4*d +: 4] >= 4'd5 ? scratch[4*d +: 4] + 4'd3 : scratch[4*d +: 4];
    fin = {adj[DW-2:0], prod[PW-1]};
  end
  // leading-zero blanking from the top digit down; units always shown
  always_comb begin
    shown = fin;
    seen  = 1'b0;
    for (int d = DIGITS - 1; d > 0; d--) begin
      seen              = seen | (fin[4*d +: 4] != 4'h0);
      shown[4*d +: 4]   = seen ? fin[4*d +: 4] : BLANK;
    end
  end
  // datapath: latch code, multiply, iterate, and publish the result as FMT is entered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      code    <= '0;
      prod    <= '0;
      scratch <= '0;
      cnt     <= '0;
      digitos <= RST_DIG;
      err     <= 1'b0;
    end else begin
      if (accept) code <= bus.corriente;
      if (state == LOAD) begin
        prod    <= PW'(code) * PW'(STEP);
        scratch <= '0;
        cnt     <= CW'(PW);
      end
      if (state == SHIFT) begin
        scratch <= fin;
        prod    <= prod << 1;
        cnt     <= cnt - 1'b1;
      end
      if (last) begin
        digitos <= bad ? '0 : shown;
        err     <= bad;
      end
    end
  assign bus.digitos = digitos;
  assign bus.err     = err;
  assign bus.busy    = state == LOAD || state == SHIFT;
  assign bus.done    = state == FMT;
endmodule

// File: tb/tb_conv_corriente_bcd.sv
// tb_conv_corriente_bcd: directed checks of conversion results, timing, blanking, errors and reset
module tb_conv_corriente_bcd;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  conv_corriente_bcd_if #(.IN_W(5), .DIGITS(4)) bus ();
  conv_corriente_bcd dut (.clk(clk), .reset(reset), .bus(bus));
  // pulse start with code c, wait (bounded) for done; lat = cycles after accept edge, 0 on timeout
  task automatic convert(input logic [4:0] c, output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.corriente = c;
    @(negedge clk);
    bus.start = 1'b0;
    bus.corriente = ~c;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    bus.start = 1'b0;
    bus.corriente = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.digitos !== 16'hAAA0) begin errors++; $display("FAIL reset_dig got %h want %h", bus.digitos, 16'hAAA0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
  endtask
  task automatic test_basic();
    int lat, bn;
    convert(5'd13, lat, bn);
    checks++; if (lat !== 13) begin errors++; $display("FAIL basic_latency got %0d want 13", lat); end
    checks++; if (bus.digitos !== 16'hA650) begin errors++; $display("FAIL basic_dig got %h want %h", bus.digitos, 16'hA650); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", bus.err); end
    checks++; if (bn !== 12) begin errors++; $display("FAIL basic_busy_cycles got %0d want 12", bn); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", bus.busy); end
  endtask
  task automatic test_values();
    logic [4:0]  codes [5] = '{5'd0, 5'd1, 5'd20, 5'd21, 5'd2};
    logic [15:0] digs  [5] = '{16'hAAA0, 16'hAA50, 16'h1000, 16'h0000, 16'hA100};
    logic        errs  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, bn;
    for (int i = 0; i < 5; i++) begin
      convert(codes[i], lat, bn);
      checks++; if (lat !== 13) begin errors++; $display("FAIL values_latency code=%0d got %0d want 13", codes[i], lat); end
      checks++; if (bus.digitos !== digs[i]) begin errors++; $display("FAIL values_dig code=%0d got %h want %h", codes[i], bus.digitos, digs[i]); end
      checks++; if (bus.err !== errs[i]) begin errors++; $display("FAIL values_err code=%0d got %b want %b", codes[i], bus.err, errs[i]); end
    end
    repeat (4) @(negedge clk);
    checks++; if (bus.digitos !== 16'hA100) begin errors++; $display("FAIL hold_dig got %h want %h", bus.digitos, 16'hA100); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL hold_done got %b want 0", bus.done); end
  endtask
  task automatic test_ignore();
    int dn = 0;
    logic [15:0] dig = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.corriente = 5'd13;
    @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      bus.start = (k == 4);
      bus.corriente = (k == 4) ? 5'd7 : 5'd13;
      if (bus.done) begin
        dn++;
        dig = bus.digitos;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_count got %0d want 1", dn); end
    checks++; if (dig !== 16'hA650) begin errors++; $display("FAIL ignore_dig got %h want %h", dig, 16'hA650); end
  endtask
  task automatic test_mid_reset();
    int dn = 0;
    int lat, bn;
    @(negedge clk);
    bus.start = 1'b1;
    bus.corriente = 5'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.digitos !== 16'hAAA0) begin errors++; $display("FAIL midrst_dig got %h want %h", bus.digitos, 16'hAAA0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", bus.err); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dn); end
    convert(5'd19, lat, bn);
    checks++; if (lat !== 13) begin errors++; $display("FAIL after_rst_latency got %0d want 13", lat); end
    checks++; if (bus.digitos !== 16'hA950) begin errors++; $display("FAIL after_rst_dig got %h want %h", bus.digitos, 16'hA950); end
  endtask
  task automatic test_back_to_back();
    int first = 0;
    int second = 0;
    logic [15:0] d1 = 'x;
    logic [15:0] d2 = 'x;
    @(negedge clk);
    bus.start = 1'b1;
    bus.corriente = 5'd3;
    @(negedge clk);
    for (int k = 1; k <= 30; k++) begin
      if (bus.done && first == 0) begin first = k; d1 = bus.digitos; end
      else if (bus.done && second == 0) begin second = k; d2 = bus.digitos; end
      @(negedge clk);
    end
    bus.start = 1'b0;
    for (int k = 0; k < 40 && (bus.busy || bus.done); k++) @(negedge clk);
    checks++; if (first !== 13) begin errors++; $display("FAIL b2b_first got %0d want 13", first); end
    checks++; if (second !== 26) begin errors++; $display("FAIL b2b_second got %0d want 26", second); end
    checks++; if (d1 !== 16'hA150) begin errors++; $display("FAIL b2b_dig1 got %h want %h", d1, 16'hA150); end
    checks++; if (d2 !== 16'hA150) begin errors++; $display("FAIL b2b_dig2 got %h want %h", d2, 16'hA150); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", bus.busy); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_values();
    test_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
